// File: rtl/param_universal_shift_reg.sv
// Parametrised universal shift register with an N-position burst sequencer.
// Optional rotate modes (sel 101/110) are enabled by defining USR_ROTATE_EN.
module param_universal_shift_reg #(
    parameter int                  WIDTH     = 8,
    parameter logic [WIDTH-1:0]    RESET_VAL = '0,
    localparam int                 SW        = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       sel,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic             start,
    input  logic [SW-1:0]    shamt,
    output logic [WIDTH-1:0] q,
    output logic             sout_r,
    output logic             sout_l,
    output logic             busy,
    output logic             done
);

    // state | meaning
    // IDLE  | single-step ops on en, burst launch on start
    // RUN   | applies latched op once per cycle until count reaches 0
    // DONE  | one-cycle completion pulse, q holds
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic [SW-1:0]    cnt, cnt_nxt;
    logic [2:0]       op, op_nxt;

    function automatic logic [WIDTH-1:0] apply_op(
        input logic [2:0]       code,
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] din,
        input logic             sr,
        input logic             sl
    );
        logic [WIDTH-1:0] res;
        res = cur;
        case (code)
            3'b001:  res = {sr, cur[WIDTH-1:1]};
            3'b010:  res = {cur[WIDTH-2:0], sl};
            3'b011:  res = din;
            3'b100:  res = {cur[WIDTH-1], cur[WIDTH-1:1]};
`ifdef USR_ROTATE_EN
            3'b101:  res = {cur[0], cur[WIDTH-1:1]};
            3'b110:  res = {cur[WIDTH-2:0], cur[WIDTH-1]};
`endif
            default: res = cur;
        endcase
        return res;
    endfunction

    function automatic logic is_shift(input logic [2:0] code);
        logic r;
        case (code)
            3'b001, 3'b010, 3'b100: r = 1'b1;
`ifdef USR_ROTATE_EN
            3'b101, 3'b110:         r = 1'b1;
`endif
            default:                r = 1'b0;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            q     <= RESET_VAL;
            cnt   <= '0;
            op    <= '0;
        end else begin
            state <= state_nxt;
            q     <= q_nxt;
            cnt   <= cnt_nxt;
            op    <= op_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        q_nxt     = q;
        cnt_nxt   = cnt;
        op_nxt    = op;
        case (state)
            IDLE: begin
                if (start) begin
                    if (is_shift(sel) && (shamt != '0)) begin
                        op_nxt    = sel;
                        // saturate oversize requests to a full-width burst
                        cnt_nxt   = (shamt > SW'(WIDTH)) ? SW'(WIDTH) : shamt;
                        state_nxt = RUN;
                    end else begin
                        state_nxt = DONE;
                    end
                end else if (en) begin
                    q_nxt = apply_op(sel, q, d, sin_r, sin_l);
                end
            end
            RUN: begin
                q_nxt   = apply_op(op, q, d, sin_r, sin_l);
                cnt_nxt = cnt - SW'(1);
                if (cnt == SW'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign sout_r = q[0];
    assign sout_l = q[WIDTH-1];
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

endmodule

// File: tb/tb_param_universal_shift_reg.sv
// Scoreboard bench for param_universal_shift_reg (WIDTH=8, RESET_VAL=0).
// Expected q/busy/done are queued when inputs are driven and checked after the edge.
module tb_param_universal_shift_reg;

    logic       clk;
    logic       reset;
    logic       en;
    logic [2:0] sel;
    logic [7:0] d;
    logic       sin_r;
    logic       sin_l;
    logic       start;
    logic [3:0] shamt;
    logic [7:0] q;
    logic       sout_r;
    logic       sout_l;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      tag;
        logic [7:0] q;
        logic       busy;
        logic       done;
    } exp_t;
    exp_t sb[$];

    // reference model state: 0 idle, 1 run, 2 done
    logic [7:0] m_q;
    int         m_st;
    int         m_cnt;
    logic [2:0] m_op;

    param_universal_shift_reg #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
        .clk(clk), .reset(reset), .en(en), .sel(sel), .d(d),
        .sin_r(sin_r), .sin_l(sin_l), .start(start), .shamt(shamt),
        .q(q), .sout_r(sout_r), .sout_l(sout_l), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_op(input logic [2:0] c, input logic [7:0] x,
                                          input logic [7:0] dd, input logic sr, input logic sl);
        case (c)
            3'd1: return {sr, x[7:1]};
            3'd2: return {x[6:0], sl};
            3'd3: return dd;
            3'd4: return {x[7], x[7:1]};
`ifdef USR_ROTATE_EN
            3'd5: return {x[0], x[7:1]};
            3'd6: return {x[6:0], x[7]};
`endif
            default: return x;
        endcase
    endfunction

    function automatic logic ref_shift(input logic [2:0] c);
`ifdef USR_ROTATE_EN
        return (c == 3'd1) || (c == 3'd2) || (c == 3'd4) || (c == 3'd5) || (c == 3'd6);
`else
        return (c == 3'd1) || (c == 3'd2) || (c == 3'd4);
`endif
    endfunction

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk({e.tag, ".q"}, 32'(q), 32'(e.q));
        chk({e.tag, ".busy"}, 32'(busy), 32'(e.busy));
        chk({e.tag, ".done"}, 32'(done), 32'(e.done));
        chk({e.tag, ".sout"}, {30'd0, sout_l, sout_r}, {30'd0, e.q[7], e.q[0]});
    endtask

    task automatic push_exp(input string tag);
        exp_t e;
        e.tag  = tag;
        e.q    = m_q;
        e.busy = (m_st == 1);
        e.done = (m_st == 2);
        sb.push_back(e);
    endtask

    task automatic drive(input string tag, input logic e_i, input logic [2:0] s_i,
                         input logic [7:0] d_i, input logic sr_i, input logic sl_i,
                         input logic st_i, input logic [3:0] sh_i);
        @(negedge clk);
        en = e_i; sel = s_i; d = d_i; sin_r = sr_i; sin_l = sl_i; start = st_i; shamt = sh_i;
        case (m_st)
            0: begin
                if (st_i) begin
                    if (ref_shift(s_i) && sh_i != 4'd0) begin
                        m_op  = s_i;
                        m_cnt = (sh_i > 4'd8) ? 8 : int'(sh_i);
                        m_st  = 1;
                    end else begin
                        m_st = 2;
                    end
                end else if (e_i) begin
                    m_q = ref_op(s_i, m_q, d_i, sr_i, sl_i);
                end
            end
            1: begin
                m_q = ref_op(m_op, m_q, d_i, sr_i, sl_i);
                m_cnt--;
                if (m_cnt == 0) m_st = 2;
            end
            default: m_st = 0;
        endcase
        push_exp(tag);
        @(posedge clk);
        #1;
        pop_check();
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b0;
        m_q = 8'h00; m_st = 0; m_cnt = 0; m_op = 3'd0;
        push_exp(tag);
        #1;
        pop_check();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic op1(input string tag, input logic [2:0] s_i, input logic [7:0] d_i,
                       input logic sr_i, input logic sl_i);
        drive(tag, 1'b1, s_i, d_i, sr_i, sl_i, 1'b0, 4'd0);
    endtask

    task automatic burst(input string tag, input logic [2:0] s_i, input logic [3:0] sh_i,
                         input logic sr_i, input logic sl_i, input int cycles);
        drive({tag, "_start"}, 1'b0, s_i, 8'h00, sr_i, sl_i, 1'b1, sh_i);
        for (int i = 0; i < cycles; i++)
            drive({tag, "_run"}, 1'b1, 3'd3, 8'hFF, sr_i, sl_i, 1'b1, 4'd5);
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; sel = 3'd0; d = 8'h00;
        sin_r = 1'b0; sin_l = 1'b0; start = 1'b0; shamt = 4'd0;
        m_q = 8'h00; m_st = 0; m_cnt = 0; m_op = 3'd0;
        #1;
        push_exp("por");
        pop_check();
        @(negedge clk);
        reset = 1'b1;

        op1("load_a5", 3'd3, 8'hA5, 1'b0, 1'b0);
        op1("shr", 3'd1, 8'h00, 1'b1, 1'b0);
        op1("shl", 3'd2, 8'h00, 1'b0, 1'b0);
        op1("hold", 3'd0, 8'h00, 1'b1, 1'b1);
        drive("en_off", 1'b0, 3'd3, 8'h3C, 1'b1, 1'b1, 1'b0, 4'd0);
        do_reset("rst_mid");
        op1("load_a5b", 3'd3, 8'hA5, 1'b0, 1'b0);

        op1("load_90", 3'd3, 8'h90, 1'b0, 1'b0);
        op1("asr", 3'd4, 8'h00, 1'b0, 1'b0);
        op1("rsvd", 3'd7, 8'h00, 1'b1, 1'b1);

        op1("load_81", 3'd3, 8'h81, 1'b0, 1'b0);
        burst("shl3", 3'd2, 4'd3, 1'b0, 1'b0, 4);
        burst("sh0", 3'd1, 4'd0, 1'b1, 1'b0, 1);
        op1("load_00", 3'd3, 8'h00, 1'b0, 1'b0);
        burst("sat15", 3'd1, 4'd15, 1'b1, 1'b0, 9);
        burst("b2b", 3'd2, 4'd2, 1'b0, 1'b1, 3);
        burst("ld_start", 3'd3, 4'd4, 1'b0, 1'b0, 1);
        op1("load_90b", 3'd3, 8'h90, 1'b0, 1'b0);
        burst("asr2", 3'd4, 4'd2, 1'b0, 1'b0, 3);
        burst("shr8", 3'd1, 4'd8, 1'b0, 1'b1, 9);

        op1("load_81r", 3'd3, 8'h81, 1'b0, 1'b0);
        op1("rotr", 3'd5, 8'h00, 1'b0, 1'b0);
        op1("load_81l", 3'd3, 8'h81, 1'b0, 1'b0);
        op1("rotl", 3'd6, 8'h00, 1'b0, 1'b0);
        burst("rotr_b", 3'd5, 4'd3, 1'b0, 1'b0, 4);

        op1("load_00b", 3'd3, 8'h00, 1'b0, 1'b0);
        drive("abort_start", 1'b0, 3'd1, 8'h00, 1'b1, 1'b0, 1'b1, 4'd8);
        drive("abort_s1", 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0, 4'd0);
        drive("abort_s2", 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0, 4'd0);
        do_reset("abort_rst");
        for (int i = 0; i < 3; i++)
            drive("post_abort", 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 1'b0, 4'd0);

        for (int i = 0; i < 200; i++) begin
            logic [3:0] r_sh;
            r_sh = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
            drive("rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0), r_sh);
        end

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
